// File: rtl/gmii_to_rgmii.sv
// Transmit-side GMII to RGMII converter: registered byte path, same-edge DDR nibble mux,
// forwarded TXC and per-frame debug counters.
module gmii_to_rgmii #(
   parameter int PIPE_STAGES = 1,
   parameter int TXC_INVERT  = 0,
   parameter int CNT_W       = 16
) (
   input  logic             gmii_tx_clk,
   input  logic             reset,
   input  logic [7:0]       gmii_txd,
   input  logic             gmii_tx_en,
   input  logic             gmii_tx_er,
   output logic [3:0]       rgmii_txd,
   output logic             rgmii_tx_clk,
   output logic             rgmii_tx_ctl,
   output logic [CNT_W-1:0] tx_frame_cnt,
   output logic [CNT_W-1:0] tx_err_cnt
);

   // each stage holds {txd, en, er}
   logic [9:0] stage [PIPE_STAGES];
   logic [7:0] s_d;
   logic       s_en;
   logic       s_er;
   logic       r_en;
   logic       r_er;
   logic       en_d;
   logic       err_flag;
   logic       frame_end;
   logic [4:0] neg_q;

   always_ff @(posedge gmii_tx_clk) begin
      if (reset) begin
         for (int i = 0; i < PIPE_STAGES; i++) stage[i] <= '0;
      end else begin
         stage[0] <= {gmii_txd, gmii_tx_en, gmii_tx_er};
         for (int i = 1; i < PIPE_STAGES; i++) stage[i] <= stage[i-1];
      end
   end

   assign s_d  = stage[PIPE_STAGES-1][9:2];
   assign s_en = stage[PIPE_STAGES-1][1];
   assign s_er = stage[PIPE_STAGES-1][0];
   assign r_en = stage[0][1];
   assign r_er = stage[0][0];

   // Low-half values come from the same registered byte, latched at the falling edge,
   // so each half-period shows nibbles of exactly one byte.
   always_ff @(negedge gmii_tx_clk) begin
      neg_q <= {s_d[7:4], s_en ^ s_er};
   end

   always_comb begin
      rgmii_txd    = neg_q[4:1];
      rgmii_tx_ctl = neg_q[0];
      if (gmii_tx_clk) begin
         rgmii_txd    = s_d[3:0];
         rgmii_tx_ctl = s_en;
      end
   end

   assign rgmii_tx_clk = (TXC_INVERT != 0) ? ~gmii_tx_clk : gmii_tx_clk;

   assign frame_end = en_d & ~r_en;

   always_ff @(posedge gmii_tx_clk) begin
      if (reset) begin
         en_d         <= 1'b0;
         err_flag     <= 1'b0;
         tx_frame_cnt <= '0;
         tx_err_cnt   <= '0;
      end else begin
         en_d <= r_en;
         if (frame_end) begin
            tx_frame_cnt <= tx_frame_cnt + 1'b1;
            if (err_flag) tx_err_cnt <= tx_err_cnt + 1'b1;
            err_flag <= 1'b0;
         end else if (r_en && r_er) begin
            err_flag <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_gmii_to_rgmii.sv
// Bench for gmii_to_rgmii: two instances (default and inverted-TXC/deep-pipe/narrow-counter)
// compared every half-period against a per-edge input history and a frame-level counter model.
module tb_gmii_to_rgmii;

   localparam int MAXC = 4096;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] txd;
   logic       en;
   logic       er;

   logic [3:0]  a_txd, b_txd;
   logic        a_clk, b_clk, a_ctl, b_ctl;
   logic [15:0] a_fc, a_ec;
   logic [2:0]  b_fc, b_ec;

   gmii_to_rgmii #(.PIPE_STAGES(1), .TXC_INVERT(0), .CNT_W(16)) dut_a (
      .gmii_tx_clk(clk), .reset(reset), .gmii_txd(txd), .gmii_tx_en(en), .gmii_tx_er(er),
      .rgmii_txd(a_txd), .rgmii_tx_clk(a_clk), .rgmii_tx_ctl(a_ctl),
      .tx_frame_cnt(a_fc), .tx_err_cnt(a_ec));

   gmii_to_rgmii #(.PIPE_STAGES(3), .TXC_INVERT(1), .CNT_W(3)) dut_b (
      .gmii_tx_clk(clk), .reset(reset), .gmii_txd(txd), .gmii_tx_en(en), .gmii_tx_er(er),
      .rgmii_txd(b_txd), .rgmii_tx_clk(b_clk), .rgmii_tx_ctl(b_ctl),
      .tx_frame_cnt(b_fc), .tx_err_cnt(b_ec));

   always #4 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   logic [7:0] h_d   [MAXC];
   logic       h_en  [MAXC];
   logic       h_er  [MAXC];
   logic       h_rst [MAXC];

   // frame-level counter model
   int fc = 0, ec = 0;
   bit err_seen = 0, pend = 0, pend_err = 0, prev_en = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      if (obs !== exp) begin
         fails++;
         $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, obs, exp);
      end
   endtask

   // Byte on the DDR output after edge m for a p-stage pipe: the byte sampled p-1 edges
   // earlier, or zero if any reset was sampled since then.
   function automatic bit exp_byte(input int p, input int m, output logic [9:0] v);
      int j = m - p + 1;
      for (int k = (j < 1 ? 1 : j); k <= m; k++)
         if (h_rst[k]) begin
            v = '0;
            return 1'b1;
         end
      if (j < 1) begin
         v = '0;
         return 1'b0;
      end
      v = {h_d[j], h_en[j], h_er[j]};
      return 1'b1;
   endfunction

   task automatic model_edge(input bit r, input bit e, input bit x);
      if (r) begin
         fc = 0; ec = 0; err_seen = 0; pend = 0; prev_en = 0;
      end else begin
         if (pend) begin
            fc++;
            if (pend_err) ec++;
            pend = 0;
         end
         if (prev_en && !e) begin
            pend = 1; pend_err = err_seen; err_seen = 0;
         end
         if (e && x) err_seen = 1;
         prev_en = e;
      end
   endtask

   task automatic step(input bit r, input bit e, input bit x, input logic [7:0] d);
      logic [9:0] va, vb;
      bit oka, okb;
      reset = r; en = e; er = x; txd = d;
      @(posedge clk);
      cyc++;
      if (cyc >= MAXC) begin
         $display("FAIL cycle_budget cyc=%0d got=%0d exp=%0d", cyc, cyc, MAXC - 1);
         fails++;
         $display("[TB] %0d tests run, %0d failed", tests, fails);
         $fatal(1, "cycle budget exceeded");
      end
      h_d[cyc] = d; h_en[cyc] = e; h_er[cyc] = x; h_rst[cyc] = r;
      model_edge(r, e, x);
      oka = exp_byte(1, cyc, va);
      okb = exp_byte(3, cyc, vb);
      #2;
      chk("txc_a_hi", 32'(a_clk), 32'd1);
      chk("txc_b_hi", 32'(b_clk), 32'd0);
      chk("frame_cnt_a", 32'(a_fc), 32'(fc & 16'hFFFF));
      chk("err_cnt_a",   32'(a_ec), 32'(ec & 16'hFFFF));
      chk("frame_cnt_b", 32'(b_fc), 32'(fc & 7));
      chk("err_cnt_b",   32'(b_ec), 32'(ec & 7));
      if (oka) begin
         chk("txd_a_hi", 32'(a_txd), 32'(va[5:2]));
         chk("ctl_a_hi", 32'(a_ctl), 32'(va[1]));
      end
      if (okb) begin
         chk("txd_b_hi", 32'(b_txd), 32'(vb[5:2]));
         chk("ctl_b_hi", 32'(b_ctl), 32'(vb[1]));
      end
      #4;
      chk("txc_a_lo", 32'(a_clk), 32'd0);
      chk("txc_b_lo", 32'(b_clk), 32'd1);
      if (oka) begin
         chk("txd_a_lo", 32'(a_txd), 32'(va[9:6]));
         chk("ctl_a_lo", 32'(a_ctl), 32'(va[1] ^ va[0]));
      end
      if (okb) begin
         chk("txd_b_lo", 32'(b_txd), 32'(vb[9:6]));
         chk("ctl_b_lo", 32'(b_ctl), 32'(vb[1] ^ vb[0]));
      end
      #1;
   endtask

   initial begin
      logic [3:0] n;
      bit e;
      reset = 1'b1; en = 1'b0; er = 1'b0; txd = 8'h00;

      for (int i = 0; i < 16; i++) step(1, 0, 0, 8'($urandom));
      for (int i = 0; i < 4; i++)  step(0, 0, 0, 8'h00);

      // 16-byte ramp 0A,1B,...,F9 sent twice
      for (int i = 0; i < 32; i++) begin
         n = 4'(i);
         step(0, 1, 0, {n, n + 4'hA});
      end
      for (int i = 0; i < 5; i++) step(0, 0, 0, 8'h00);

      for (int i = 0; i < 200; i++) step(0, 1, 0, 8'($urandom));
      for (int i = 0; i < 5; i++)   step(0, 0, 0, 8'h00);

      // error byte 3D inside a frame
      for (int i = 0; i < 6; i++) step(0, 1, 0, 8'($urandom));
      step(0, 1, 1, 8'h3D);
      for (int i = 0; i < 6; i++) step(0, 1, 0, 8'($urandom));
      for (int i = 0; i < 5; i++) step(0, 0, 0, 8'h00);

      // carrier extension: er without en
      for (int i = 0; i < 4; i++) step(0, 0, 1, 8'h0F);
      for (int i = 0; i < 3; i++) step(0, 0, 0, 8'h00);

      // reset mid-frame, with an error already flagged
      for (int i = 0; i < 5; i++) step(0, 1, (i == 1), 8'h82);
      for (int i = 0; i < 3; i++) step(1, 1, 0, 8'h82);
      for (int i = 0; i < 5; i++) step(0, 0, 0, 8'h00);

      // frame end coinciding with reset
      for (int i = 0; i < 4; i++) step(0, 1, 1, 8'h55);
      step(0, 0, 0, 8'h00);
      step(1, 0, 0, 8'h00);
      for (int i = 0; i < 4; i++) step(0, 0, 0, 8'h00);

      e = 0;
      for (int i = 0; i < 2500; i++) begin
         if (e) e = ($urandom_range(0, 9) != 0);
         else   e = ($urandom_range(0, 4) == 0);
         step(($urandom_range(0, 299) == 0), e, ($urandom_range(0, 14) == 0), 8'($urandom));
      end
      for (int i = 0; i < 5; i++) step(0, 0, 0, 8'h00);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
